i2s_rx_deserializer: RTL and testbench

- Upstream capture stage for the audio path. Receives a standard I2S stream from the ADC (serial_clk, word_select, serial data) and deserializes it into parallel left/right 16-bit samples.
- Hands each completed stereo frame to the processing/transmit side with a one-cycle valid pulse.
- Runs entirely on input_clk (12.288 MHz). It oversamples the 3.072 MHz bit clock, 4 input_clk per bit.

---
 rtl/i2s_rx_deserializer.sv | 161 ++++++++++++++++
 tb/tb_i2s_rx_deserializer.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2s_rx_deserializer.sv
// I2S receiver: oversampled bit capture, frame alignment, stereo word output.
// Define I2S_RX_ERR_CNT_EN to build the saturating frame error counter.
module i2s_rx_deserializer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    input_clk,
  input  logic                    reset,
  input  logic                    serial_clk_in,
  input  logic                    word_select_in,
  input  logic                    sound_bit_in,
  output logic [SAMPLE_WIDTH-1:0] left_sample,
  output logic [SAMPLE_WIDTH-1:0] right_sample,
  output logic                    sample_valid,
  output logic                    frame_err,
  output logic                    locked,
  output logic [7:0]              err_count
);

  localparam int CW = $clog2(SAMPLE_WIDTH + 2);
  localparam logic [CW-1:0] CNT_WORD = CW'(SAMPLE_WIDTH);
  localparam logic [CW-1:0] CNT_MAX  = CW'(SAMPLE_WIDTH + 1);

  typedef enum logic [1:0] {
    SYNC,
    LEFT,
    RIGHT
  } state_t;

  logic [SYNC_STAGES-1:0]  sclk_sync_q;
  logic [SYNC_STAGES-1:0]  ws_sync_q;
  logic [SYNC_STAGES-1:0]  sd_sync_q;
  logic                    sclk_dly_q;

  state_t                  state_q, state_d;
  logic [SAMPLE_WIDTH-2:0] shift_q, shift_d;
  logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
  logic                    ws_last_q, ws_last_d;
  logic [SAMPLE_WIDTH-1:0] left_hold_q, left_hold_d;
  logic [SAMPLE_WIDTH-1:0] left_q, left_d;
  logic [SAMPLE_WIDTH-1:0] right_q, right_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;

  logic                    sclk_s, ws_s, sd_s;
  logic                    sclk_rise, boundary;
  logic                    word_ok, overrun;
  logic [CW-1:0]           cnt_inc;
  logic [SAMPLE_WIDTH-1:0] word;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ws_s      = ws_sync_q[SYNC_STAGES-1];
  assign sd_s      = sd_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign boundary  = sclk_rise & (ws_s ^ ws_last_q);
  assign cnt_inc   = (bit_cnt_q == CNT_MAX) ? CNT_MAX
                                            : bit_cnt_q + 1'b1;
  assign word      = {shift_q, sd_s};
  assign word_ok   = (cnt_inc == CNT_WORD);
  assign overrun   = ~boundary & (cnt_inc == CNT_MAX);

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    ws_last_d   = ws_last_q;
    left_hold_d = left_hold_q;
    left_d      = left_q;
    right_d     = right_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    if (sclk_rise) begin
      shift_d   = word[SAMPLE_WIDTH-2:0];
      ws_last_d = ws_s;
      bit_cnt_d = boundary ? '0 : cnt_inc;
      case (state_q)
        SYNC: begin
          if (boundary && ws_last_q) state_d = LEFT;
        end
        LEFT: begin
          if (boundary && word_ok) begin
            left_hold_d = word;
            state_d     = RIGHT;
          end else if (boundary || overrun) begin
            err_d   = 1'b1;
            state_d = SYNC;
          end
        end
        RIGHT: begin
          if (boundary && word_ok) begin
            left_d  = left_hold_q;
            right_d = word;
            valid_d = 1'b1;
            state_d = LEFT;
          end else if (boundary || overrun) begin
            err_d   = 1'b1;
            state_d = SYNC;
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

  always_ff @(posedge input_clk) begin
    if (!reset) begin
      sclk_sync_q <= '0;
      ws_sync_q   <= '0;
      sd_sync_q   <= '0;
      sclk_dly_q  <= 1'b0;
      state_q     <= SYNC;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      ws_last_q   <= 1'b0;
      left_hold_q <= '0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], serial_clk_in};
      ws_sync_q   <= {ws_sync_q[SYNC_STAGES-2:0], word_select_in};
      sd_sync_q   <= {sd_sync_q[SYNC_STAGES-2:0], sound_bit_in};
      sclk_dly_q  <= sclk_s;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      ws_last_q   <= ws_last_d;
      left_hold_q <= left_hold_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

`ifdef I2S_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge input_clk) begin
    if (!reset) err_cnt_q <= '0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = 8'd0;
`endif

  assign left_sample  = left_q;
  assign right_sample = right_q;
  assign sample_valid = valid_q;
  assign frame_err    = err_q;
  assign locked       = (state_q != SYNC);

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Bench for i2s_rx_deserializer: frame table, scoreboard, error corners.
// Expected err_count follows I2S_RX_ERR_CNT_EN.
module tb_i2s_rx_deserializer;

  logic        clk;
  logic        rst_n;
  logic        sclk_pin, ws_pin, sd_pin;
  logic [15:0] left_sample, right_sample;
  logic        sample_valid, frame_err, locked;
  logic [7:0]  err_count;

  i2s_rx_deserializer #(
    .SAMPLE_WIDTH(16),
    .SYNC_STAGES (2)
  ) dut (
    .input_clk     (clk),
    .reset         (rst_n),
    .serial_clk_in (sclk_pin),
    .word_select_in(ws_pin),
    .sound_bit_in  (sd_pin),
    .left_sample   (left_sample),
    .right_sample  (right_sample),
    .sample_valid  (sample_valid),
    .frame_err     (frame_err),
    .locked        (locked),
    .err_count     (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
  } pair_t;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    bit          expv;
  } vec_t;

  pair_t exp_q[$];
  vec_t  vecs[7];
  int    checks   = 0;
  int    failures = 0;
  int    err_seen = 0;
  int    inj      = 0;
  bit    started  = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_cnt(input int n);
`ifdef I2S_RX_ERR_CNT_EN
    return (n > 255) ? 8'd255 : 8'(n);
`else
    return 8'd0;
`endif
  endfunction

  always @(negedge clk) begin
    if (started && rst_n) begin
      if (sample_valid) begin
        chk("valid_excl_err", {31'd0, frame_err}, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", {31'd0, sample_valid}, 0);
        end else begin
          pair_t p;
          p = exp_q.pop_front();
          chk("left_sample", {16'd0, left_sample}, {16'd0, p.l});
          chk("right_sample", {16'd0, right_sample}, {16'd0, p.r});
        end
      end
      if (frame_err) begin
        err_seen++;
        chk("locked_on_err", {31'd0, locked}, 0);
      end
    end
  end

  task automatic slot(input logic ws, input logic sd);
    sclk_pin = 1'b0;
    ws_pin   = ws;
    sd_pin   = sd;
    repeat (2) @(posedge clk);
    #1 sclk_pin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    sclk_pin = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic ch, input logic [15:0] d,
                           input int nbits, input logic nws);
    for (int i = nbits - 1; i >= 1; i--) slot(ch, d[i]);
    slot(nws, d[0]);
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r,
                            input bit expv);
    pair_t p;
    if (expv) begin
      p.l = l;
      p.r = r;
      exp_q.push_back(p);
    end
    send_word(1'b0, l, 16, 1'b1);
    send_word(1'b1, r, 16, 1'b0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst_n = 1'b1;
    inj      = 0;
    err_seen = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_left"}, {16'd0, left_sample}, 0);
    chk({tag, "_right"}, {16'd0, right_sample}, 0);
    chk({tag, "_valid"}, {31'd0, sample_valid}, 0);
    chk({tag, "_err"}, {31'd0, frame_err}, 0);
    chk({tag, "_locked"}, {31'd0, locked}, 0);
    chk({tag, "_errcnt"}, {24'd0, err_count}, 0);
  endtask

  task automatic chk_drained(input string tag);
    idle(12);
    chk({tag, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    logic [15:0] d;
    vecs[0] = '{16'h7D00, 16'h8300, 1'b0};
    vecs[1] = '{16'h7D00, 16'h8300, 1'b1};
    vecs[2] = '{16'h7D00, 16'h8300, 1'b1};
    vecs[3] = '{16'h1234, 16'hABCD, 1'b1};
    vecs[4] = '{16'h8000, 16'h7FFF, 1'b1};
    vecs[5] = '{16'hFFFF, 16'h0001, 1'b1};
    vecs[6] = '{16'h0000, 16'hFFFF, 1'b1};

    sclk_pin = 1'b0;
    ws_pin   = 1'b0;
    sd_pin   = 1'b0;
    @(negedge clk);
    do_reset(3);
    started = 1;
    @(negedge clk);
    chk_reset_vals("rst");

    for (int i = 0; i < 7; i++) begin
      send_frame(vecs[i].l, vecs[i].r, vecs[i].expv);
      if (i == 0) begin
        idle(8);
        chk("locked_after_sync", {31'd0, locked}, 1);
      end
    end
    chk_drained("table");
    chk("table_no_err", err_seen, 0);

    do_reset(1);
    for (int i = 6; i >= 1; i--) slot(1'b1, 1'b1);
    slot(1'b0, 1'b0);
    idle(8);
    chk("midright_locked", {31'd0, locked}, 1);
    send_frame(16'h4242, 16'hBEEF, 1'b1);
    send_frame(16'hC0DE, 16'h0F0F, 1'b1);
    chk_drained("midright");

    send_word(1'b0, 16'h1111, 15, 1'b1);
    inj++;
    idle(8);
    chk("short_err_seen", err_seen, 1);
    chk("short_unlocked", {31'd0, locked}, 0);
    send_word(1'b1, 16'h2222, 16, 1'b0);
    send_frame(16'h7D00, 16'h8300, 1'b1);
    chk_drained("short");
    chk("short_errcnt", {24'd0, err_count}, {24'd0, exp_cnt(inj)});

    for (int i = 0; i < 16; i++) slot(1'b0, 1'($urandom_range(1)));
    idle(8);
    chk("stuck16_no_err", err_seen, 1);
    chk("stuck16_locked", {31'd0, locked}, 1);
    slot(1'b0, 1'b1);
    inj++;
    idle(8);
    chk("stuck17_err", err_seen, 2);
    chk("stuck17_unlocked", {31'd0, locked}, 0);
    for (int i = 0; i < 3; i++) slot(1'b0, 1'b0);
    idle(8);
    chk("stuck20_one_err", err_seen, 2);
    chk("stuck_errcnt", {24'd0, err_count}, {24'd0, exp_cnt(inj)});
    send_word(1'b1, 16'h3333, 16, 1'b0);
    send_frame(16'h5A5A, 16'hA5A5, 1'b1);
    chk_drained("stuck");

    d = 16'h9876;
    for (int i = 15; i >= 8; i--) slot(1'b0, d[i]);
    do_reset(1);
    @(negedge clk);
    chk_reset_vals("midrst");
    for (int i = 7; i >= 1; i--) slot(1'b0, d[i]);
    slot(1'b1, d[0]);
    send_word(1'b1, 16'h4444, 16, 1'b0);
    idle(8);
    chk("midrst_no_valid", exp_q.size(), 0);
    send_frame(16'h0123, 16'hFEDC, 1'b1);
    chk_drained("midrst");

    do_reset(1);
    slot(1'b1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      slot(1'b0, 1'b0);
      slot(1'b1, 1'b0);
      inj++;
    end
    idle(8);
    chk("sat_err_seen", err_seen, 300);
    chk("sat_errcnt", {24'd0, err_count}, {24'd0, exp_cnt(inj)});
    chk("sat_unlocked", {31'd0, locked}, 0);
    chk_drained("sat");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
